mc_ctrl_fsm: RTL

- Multicycle control sequencer for the MIPS core. Drives a shared-memory multicycle datapath: PC register, instruction register, register file, ALU, and a unified memory with a ready handshake.
- Decodes op/funct and steps each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on memory wait states, traps ALU overflow, and halts on illegal opcodes or memory timeout.

---
 rtl/mc_ctrl_fsm.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS control sequencer
// Moore-decoded control with mem_ready/zero-qualified strobes, wait timeout and overflow trap.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       memreq,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       exc,
  output logic       halted
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
    RTYPEWB, ADDIEX, ADDIWB, BEQEX, JEX, EXC, ERR
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  assign timeout = (cnt_q >= CNT_W'(MEM_TIMEOUT));

  always_comb begin
    logic arith;
    logic illegal;
    arith      = 1'b0;
    illegal    = 1'b0;
    state_d    = state_q;
    cnt_d      = '0;
    memreq     = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    exc        = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        memreq     = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        irwrite    = mem_ready;
        pcwrite    = mem_ready;
        if (mem_ready)    state_d = DECODE;
        else if (timeout) state_d = ERR;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = ERR;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_d    = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
        if (mem_ready)    state_d = MEMWB;
        else if (timeout) state_d = ERR;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready)    state_d = FETCH;
        else if (timeout) state_d = ERR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: begin alucontrol = 3'b010; arith = 1'b1; end
          6'b100010: begin alucontrol = 3'b110; arith = 1'b1; end
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   illegal = 1'b1;
        endcase
        if (illegal)                state_d = ERR;
        else if (arith && overflow) state_d = EXC;
        else                        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = FETCH;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_d    = overflow ? EXC : ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcwrite    = zero;
        state_d    = FETCH;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      EXC: begin
        exc     = 1'b1;
        state_d = FETCH;
      end
      ERR:     halted  = 1'b1;
      default: state_d = ERR;
    endcase
    // Only a stalled memory state keeps counting; any state change restarts from zero.
    if (state_d == state_q && memreq && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
    if (!rst) begin
      memreq     = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      exc        = 1'b0;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
